// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Signed mode truncates toward zero; the remainder takes the dividend's sign.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   i_start             : request, sampled only while idle
//   i_signed_mode       : 1 = two's-complement operands (captured with start)
//   i_dividend/divisor  : operands (captured with start)
//   o_busy              : high while dividing and during the fix-up cycle
//   o_done              : one-cycle pulse, results valid from this cycle on
//   o_quotient/remainder: results, held until the next done or reset
//   o_div_by_zero       : last operation had divisor == 0
//   o_overflow          : last operation was signed MIN / -1
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_signed_mode,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  // P is kept WIDTH bits wide: after each step it is below the divisor, so
  // the extra bit only exists in the shifted value fed to the subtractor.
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_dvd_neg, w_dvs_neg, w_zero, w_ovf;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_a_sh, w_quo, w_rem;
  logic [WIDTH:0]   w_p_sh, w_t;

  // MIN negates to itself, which is already the right unsigned magnitude
  assign w_dvd_neg = i_signed_mode & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_signed_mode & i_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;
  assign w_zero    = (i_divisor == '0);
  assign w_ovf     = i_signed_mode && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (&i_divisor);

  assign w_p_sh = {r_p, r_a[WIDTH-1]};
  assign w_a_sh = {r_a[WIDTH-2:0], 1'b0};
  assign w_t    = w_p_sh - {1'b0, r_d};

  // On divide-by-zero r_a still holds the raw dividend
  assign w_quo = r_dbz ? '1  : (r_sign_q ? -r_a : r_a);
  assign w_rem = r_dbz ? r_a : (r_sign_r ? -r_p : r_p);

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_p           <= '0;
      r_a           <= '0;
      r_d           <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf         <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_p   <= '0;
            r_cnt <= CW'(WIDTH-1);
            r_dbz <= w_zero;
            r_ovf <= w_ovf & ~w_zero;
            if (w_zero) begin
              r_a      <= i_dividend;
              r_d      <= '0;
              r_sign_q <= 1'b0;
              r_sign_r <= 1'b0;
              r_state  <= S_FIX;
            end else begin
              r_a      <= w_dvd_mag;
              r_d      <= w_dvs_mag;
              r_sign_q <= w_dvd_neg ^ w_dvs_neg;
              r_sign_r <= w_dvd_neg;
              r_state  <= S_DIV;
            end
          end
        end
        S_DIV: begin
          // restoring step: keep the difference only when it did not borrow
          if (!w_t[WIDTH]) begin
            r_p <= w_t[WIDTH-1:0];
            r_a <= w_a_sh | WIDTH'(1);
          end else begin
            r_p <= w_p_sh[WIDTH-1:0];
            r_a <= w_a_sh;
          end
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_FIX: begin
          o_quotient    <= w_quo;
          o_remainder   <= w_rem;
          o_div_by_zero <= r_dbz;
          o_overflow    <= r_ovf;
          o_done        <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sm = 1'b0;
  logic [63:0] dvd = '0, dvs = '0;
  logic [2:0]  st = '0;

  logic b8, d8, z8, v8, b16, d16, z16, v16, b32, d32, z32, v32;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic [31:0] q32, r32;

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .i_start(st[0]), .i_signed_mode(sm),
    .i_dividend(dvd[7:0]), .i_divisor(dvs[7:0]), .o_busy(b8), .o_done(d8),
    .o_quotient(q8), .o_remainder(r8), .o_div_by_zero(z8), .o_overflow(v8));
  seq_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .i_start(st[1]), .i_signed_mode(sm),
    .i_dividend(dvd[15:0]), .i_divisor(dvs[15:0]), .o_busy(b16), .o_done(d16),
    .o_quotient(q16), .o_remainder(r16), .o_div_by_zero(z16), .o_overflow(v16));
  seq_divider #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .i_start(st[2]), .i_signed_mode(sm),
    .i_dividend(dvd[31:0]), .i_divisor(dvs[31:0]), .o_busy(b32), .o_done(d32),
    .o_quotient(q32), .o_remainder(r32), .o_div_by_zero(z32), .o_overflow(v32));

  typedef struct {
    longint unsigned q, r;
    bit dz, ov;
    int cyc;
  } exp_t;

  exp_t e8[$], e16[$], e32[$];
  int cyc = 0;
  int nvec = 0, nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended values
  function automatic exp_t model(input int w, input bit s,
                                 input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint sa, sb;
    e.dz = 1'b0; e.ov = 1'b0; e.cyc = 0;
    a = a & m; b = b & m;
    sa = a << (64 - w); sa = sa >>> (64 - w);
    sb = b << (64 - w); sb = sb >>> (64 - w);
    if (b == 0) begin
      e.q = m; e.r = a; e.dz = 1'b1;
    end else if (s) begin
      if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
        e.q = a; e.r = 0; e.ov = 1'b1;
      end else begin
        e.q = longint'(sa / sb) & m;
        e.r = longint'(sa % sb) & m;
      end
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  function automatic exp_t mk(input int w, input bit s,
                              input longint unsigned a, input longint unsigned b);
    exp_t e = model(w, s, a, b);
    longint unsigned m = (64'd1 << w) - 64'd1;
    e.cyc = cyc + 1 + (((b & m) == 0) ? 1 : w + 1);
    return e;
  endfunction

  // Called between clock edges; start is seen on the next rising edge
  task automatic issue(input bit [2:0] msk, input bit s,
                       input longint unsigned a, input longint unsigned b);
    sm = s; dvd = a; dvs = b;
    if (msk[0]) e8.push_back(mk(8, s, a, b));
    if (msk[1]) e16.push_back(mk(16, s, a, b));
    if (msk[2]) e32.push_back(mk(32, s, a, b));
    st = msk;
    @(posedge clk); #1;
    st = '0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && (e8.size() + e16.size() + e32.size()) != 0; i++)
      @(negedge clk);
    if ((e8.size() + e16.size() + e32.size()) != 0) begin
      nvec++; nerr++;
      $display("FAIL timeout: %0d results still pending", e8.size() + e16.size() + e32.size());
      e8.delete(); e16.delete(); e32.delete();
    end
  endtask

  task automatic check_res(input string nm, input exp_t e, input longint unsigned q,
                           input longint unsigned r, input bit z, input bit v);
    chk({nm, " quotient"}, q, e.q);
    chk({nm, " remainder"}, r, e.r);
    chk({nm, " div_by_zero"}, z, e.dz);
    chk({nm, " overflow"}, v, e.ov);
    chk({nm, " done cycle"}, cyc, e.cyc);
  endtask

  // Monitors: pop the oldest expectation whenever an instance pulses done
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if ((d8 && b8) || (d16 && b16) || (d32 && b32)) begin
        nvec++; nerr++;
        $display("FAIL busy_done_overlap: busy and done both high at cycle %0d", cyc);
      end
      if (d8) begin
        if (e8.size() == 0) begin nvec++; nerr++; $display("FAIL w8 spurious done: got 1 expected 0"); end
        else begin e = e8.pop_front(); check_res("w8", e, q8, r8, z8, v8); end
      end
      if (d16) begin
        if (e16.size() == 0) begin nvec++; nerr++; $display("FAIL w16 spurious done: got 1 expected 0"); end
        else begin e = e16.pop_front(); check_res("w16", e, q16, r16, z16, v16); end
      end
      if (d32) begin
        if (e32.size() == 0) begin nvec++; nerr++; $display("FAIL w32 spurious done: got 1 expected 0"); end
        else begin e = e32.pop_front(); check_res("w32", e, q32, r32, z32, v32); end
      end
    end
  end

  task automatic outs_zero(input string nm);
    chk({nm, " busy"}, {b8, b16, b32}, 0);
    chk({nm, " done"}, {d8, d16, d32}, 0);
    chk({nm, " q16"}, q16, 0);
    chk({nm, " r16"}, r16, 0);
    chk({nm, " flags"}, {z8, v8, z16, v16, z32, v32}, 0);
    chk({nm, " q32r32"}, {q32, r32}, 0);
  endtask

  // Directed case on all widths, with the 16-bit result also held against a constant
  task automatic dir(input bit s, input longint unsigned a, input longint unsigned b,
                     input logic [15:0] eq, input logic [15:0] er, input bit ez, input bit ev);
    issue(3'b111, s, a, b);
    wait_empty();
    chk("const q16", q16, eq);
    chk("const r16", r16, er);
    chk("const flags16", {z16, v16}, {ez, ev});
  endtask

  initial begin
    longint unsigned a, b;
    #2;
    outs_zero("in reset");
    #20 rst_n = 1'b1;
    #1 outs_zero("after reset");

    dir(1, 100, 7, 16'h000E, 16'h0002, 0, 0);
    dir(1, 64'hFFFF_FFFF_FFFF_FFF9, 2, 16'hFFFD, 16'hFFFF, 0, 0);
    dir(1, 7, 64'hFFFF_FFFF_FFFF_FFFE, 16'hFFFD, 16'h0001, 0, 0);
    dir(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 16'h0003, 16'hFFFF, 0, 0);
    dir(0, 16'hFFFF, 2, 16'h7FFF, 16'h0001, 0, 0);
    dir(1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 16'h0000, 16'hFFFF, 0, 0);
    dir(1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1);
    dir(1, 16'h1234, 0, 16'hFFFF, 16'h1234, 1, 0);
    dir(0, 16'h1234, 0, 16'hFFFF, 16'h1234, 1, 0);

    // start while busy, with different operands, must be ignored
    issue(3'b111, 1, 100, 7);
    repeat (4) @(posedge clk);
    #1 dvd = 999; dvs = 5; st = 3'b111;
    @(posedge clk); #1 st = '0;
    wait_empty();
    chk("ignored start q16", q16, 16'h000E);

    // back-to-back: second start issued in the done cycle
    issue(3'b010, 1, 100, 7);
    for (int i = 0; i < 40 && !d16; i++) @(negedge clk);
    issue(3'b010, 0, 16'hFFFF, 2);
    wait_empty();
    chk("b2b q16", q16, 16'h7FFF);

    // asynchronous reset between edges mid-divide
    issue(3'b111, 1, 1000, 3);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 outs_zero("async reset");
    e8.delete(); e16.delete(); e32.delete();
    #10 rst_n = 1'b1;
    @(negedge clk);
    dir(0, 9, 3, 16'h0003, 16'h0000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 40);
      b = {$urandom, $urandom} >> $urandom_range(0, 62);
      issue(3'b111, 1'($urandom_range(0, 1)), a, b);
      wait_empty();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised, multi-cycle restoring divider for the MIPS datapath. It replaces the combinational 16-bit divider.
- Performs one quotient bit per clock.
- Supports signed (truncate-toward-zero) and unsigned modes.
- Uses a start/busy/done handshake so the core can stall on DIV/DIVU.
- Flags divide-by-zero and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 4..64).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high from the edge after start acceptance until done.
- done  output  1  one-cycle pulse; quotient/remainder/flags valid from this cycle on.
- quotient  output  WIDTH  result.
- remainder  output  WIDTH  result.
- div_by_zero  output  1  last operation had divisor == 0.
- overflow  output  1  last operation was signed MIN / -1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-operation):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0.
  - Any in-flight operation is discarded.
- States:
  - IDLE -> DIVIDE on start. Operands are captured; flags are cleared.
  - IDLE -> FIX directly if divisor == 0.
  - DIVIDE runs exactly WIDTH cycles. An iteration counter counts WIDTH-1 down to 0; the last count goes to FIX.
  - FIX lasts 1 cycle. It registers the outputs and pulses done. Next state is IDLE.
- Latency:
  - Start accepted at edge k; done is high during the cycle after edge k+WIDTH+1.
  - Divide-by-zero: done is high after edge k+1.
  - busy is high during DIVIDE and FIX; done and busy are never high in the same cycle. done is high only in the cycle right after FIX.
  - Back-to-back: start may be asserted in the done cycle (state is IDLE) and is accepted.
- start while busy: ignored, no effect on the in-flight operation.
- Operand capture (signed_mode = 1):
  - Store the magnitudes |dividend| and |divisor| in WIDTH-bit registers.
  - The MIN value stays 100..0, which is correct as unsigned.
  - Store sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB].
- Operand capture (signed_mode = 0): signs are 0 and operands are stored as-is.
- Each DIVIDE iteration:
  - Shift the partial remainder P (WIDTH+1 bits) left, bringing in the dividend MSB.
  - Shift A left.
  - Compute T = P - divisor as WIDTH+1 bits.
  - If T >= 0: P = T and A[0] = 1. Otherwise P is unchanged and A[0] = 0.
- FIX:
  - quotient = sign_q ? -A : A.
  - remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - Result invariants: dividend == quotient*divisor + remainder; |remainder| < |divisor|; the remainder takes the dividend's sign (or is 0).
- Divide-by-zero:
  - quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, overflow = 0.
  - Applies in both modes.
- Signed overflow (dividend == MIN, divisor == -1, signed_mode = 1):
  - quotient = MIN (wraps), remainder = 0, overflow = 1.
  - Full WIDTH-cycle latency.
- Outputs and flags hold their values until the next done or reset.

Test Plan:
- WIDTH=16, signed, 100 / 7 -> done 18 cycles after the start edge; quotient 0x000E, remainder 0x0002, flags 0.
- Signed -7 / 2 -> quotient 0xFFFD (-3), remainder 0xFFFF (-1). Signed 7 / -2 -> quotient 0xFFFD, remainder 0x0001. Signed -7 / -2 -> quotient 0x0003, remainder 0xFFFF.
- Unsigned 0xFFFF / 0x0002 -> quotient 0x7FFF, remainder 0x0001. The same operands signed (-1 / 2) -> quotient 0x0000, remainder 0xFFFF.
- Signed 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0x0000, overflow=1. Then 0x1234 / 0x0000 -> done 2 cycles after start; quotient 0xFFFF, remainder 0x1234, div_by_zero=1, overflow=0.
- Assert start again mid-DIVIDE with other operands -> ignored, first result unchanged. Start in the done cycle -> accepted, second result correct after a further 18 cycles.
- Pull rst_n low asynchronously mid-DIVIDE (between edges) -> busy=0 and outputs=0 immediately. After release, a new 9 / 3 gives quotient 3, remainder 0.
- Random regression for WIDTH=8, 16, 32 against the invariant above, both modes, excluding divisor 0 and the MIN/-1 case.
